// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types : shared types for the instruction-fetch stage.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2,
        FULL   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue : QDEPTH-entry FIFO of {pc, instr}; flush beats push and pop.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue
    import rv32i_types::*;
#(
    parameter int QDEPTH = 2,
    localparam int PW    = $clog2(QDEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [PW:0]  count,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t  mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(QDEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    // Storage itself is not reset; the head is forced to zero while empty.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : PC owner, imem handshake, redirect/squash, instruction queue.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(QDEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  pending_pc;
    logic [31:0]  redirect_tgt;
    logic [PW:0]  count;
    logic [PW:0]  count_after;
    logic         q_full;
    logic         q_empty;
    logic         push;
    logic         pop;
    fetch_entry_t wdata;
    fetch_entry_t head;

    assign redirect_tgt = word_align(redirect_pc);
    assign imem_read    = (state == FETCH) || (state == SQUASH);
    // In SQUASH fetch_pc is untouched, so the stale address stays on the bus.
    assign imem_address = word_align(fetch_pc);

    assign out_valid = ~q_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    assign pop         = out_valid & ~stall;
    assign push        = (state == FETCH) & imem_resp & ~redirect_valid;
    assign wdata.pc    = fetch_pc;
    assign wdata.instr = imem_rdata;
    assign count_after = count + (PW+1)'(push) - (PW+1)'(pop);

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .count (count),
        .full  (q_full),
        .empty (q_empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect_valid) begin
                        fetch_pc <= redirect_tgt;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        if (imem_resp) begin
                            fetch_pc <= redirect_tgt;
                        end else begin
                            pending_pc <= redirect_tgt;
                            state      <= SQUASH;
                        end
                    end else if (imem_resp) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (count_after == (PW+1)'(QDEPTH)) begin
                            state <= FULL;
                        end
                    end
                end
                SQUASH: begin
                    if (redirect_valid && imem_resp) begin
                        fetch_pc <= redirect_tgt;
                        state    <= FETCH;
                    end else if (redirect_valid) begin
                        pending_pc <= redirect_tgt;
                    end else if (imem_resp) begin
                        fetch_pc <= pending_pc;
                        state    <= FETCH;
                    end
                end
                FULL: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_tgt;
                        state    <= FETCH;
                    end else if (pop || !q_full) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
